// File: rtl/axi4_s_ram.sv
// AXI4 slave RAM: INCR-only bursts, full-width beats, independent read and write
// channels, DECERR outside the memory span, SLVERR on a wlast/length disagreement.
module axi4_s_ram #(
   parameter  int unsigned TAGW  = 3,
   parameter  int unsigned ADRW  = 32,
   parameter  int unsigned DATW  = 256,
   parameter  int unsigned DEPTH = 1024,
   localparam int unsigned STBW  = DATW / 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [TAGW-1:0] i_s_arid,
   input  logic [ADRW-1:0] i_s_araddr,
   input  logic [7:0]      i_s_arlen,
   input  logic            i_s_arvalid,
   output logic            o_s_arready,
   output logic [TAGW-1:0] o_s_rid,
   output logic [DATW-1:0] o_s_rdata,
   output logic [1:0]      o_s_rresp,
   output logic            o_s_rlast,
   output logic            o_s_rvalid,
   input  logic            i_s_rready,
   input  logic [TAGW-1:0] i_s_awid,
   input  logic [ADRW-1:0] i_s_awaddr,
   input  logic [7:0]      i_s_awlen,
   input  logic            i_s_awvalid,
   output logic            o_s_awready,
   input  logic [DATW-1:0] i_s_wdata,
   input  logic [STBW-1:0] i_s_wstrb,
   input  logic            i_s_wlast,
   input  logic            i_s_wvalid,
   output logic            o_s_wready,
   output logic [TAGW-1:0] o_s_bid,
   output logic [1:0]      o_s_bresp,
   output logic            o_s_bvalid,
   input  logic            i_s_bready
);

   localparam int unsigned BSH  = $clog2(STBW);
   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam logic [ADRW-1:0] SPAN = ADRW'(DEPTH * STBW);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic       {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATW-1:0] mem [DEPTH];

   r_state_t        r_state;
   logic [IDXW-1:0] r_idx;
   logic [7:0]      r_len;
   logic [7:0]      r_beat;
   logic            r_err;

   w_state_t        w_state;
   logic [IDXW-1:0] w_idx;
   logic [7:0]      w_len;
   logic [7:0]      w_beat;
   logic            w_err;
   logic            w_bad;

   logic            ar_hs;
   logic            ar_err;
   logic [IDXW-1:0] ar_idx;
   logic            aw_hs;
   logic            w_hs;
   logic            w_final;
   logic            w_mis;

   assign ar_hs   = i_s_arvalid & o_s_arready;
   assign ar_err  = i_s_araddr >= SPAN;
   assign ar_idx  = i_s_araddr[BSH +: IDXW];
   assign aw_hs   = i_s_awvalid & o_s_awready;
   assign w_hs    = i_s_wvalid & o_s_wready;
   assign w_final = w_beat == w_len;
   assign w_mis   = i_s_wlast != w_final;

   // Read channel: data is fetched one beat ahead so rvalid never bubbles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= R_IDLE;
         o_s_arready <= 1'b1;
         o_s_rvalid  <= 1'b0;
         o_s_rlast   <= 1'b0;
         o_s_rid     <= '0;
         o_s_rdata   <= '0;
         o_s_rresp   <= RESP_OKAY;
         r_idx       <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  r_state     <= R_DATA;
                  o_s_arready <= 1'b0;
                  o_s_rvalid  <= 1'b1;
                  o_s_rid     <= i_s_arid;
                  o_s_rresp   <= ar_err ? RESP_DECERR : RESP_OKAY;
                  o_s_rdata   <= ar_err ? '0 : mem[ar_idx];
                  o_s_rlast   <= i_s_arlen == 8'd0;
                  r_idx       <= ar_idx + IDXW'(1);
                  r_len       <= i_s_arlen;
                  r_beat      <= 8'd0;
                  r_err       <= ar_err;
               end
            end
            R_DATA: begin
               if (o_s_rvalid && i_s_rready) begin
                  if (o_s_rlast) begin
                     r_state     <= R_IDLE;
                     o_s_arready <= 1'b1;
                     o_s_rvalid  <= 1'b0;
                     o_s_rlast   <= 1'b0;
                  end else begin
                     o_s_rdata <= r_err ? '0 : mem[r_idx];
                     o_s_rlast <= (r_beat + 8'd1) == r_len;
                     r_idx     <= r_idx + IDXW'(1);
                     r_beat    <= r_beat + 8'd1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Write channel: beat count, not wlast, terminates the burst
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         w_state     <= W_IDLE;
         o_s_awready <= 1'b1;
         o_s_wready  <= 1'b0;
         o_s_bvalid  <= 1'b0;
         o_s_bid     <= '0;
         o_s_bresp   <= RESP_OKAY;
         w_idx       <= '0;
         w_len       <= '0;
         w_beat      <= '0;
         w_err       <= 1'b0;
         w_bad       <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  w_state     <= W_DATA;
                  o_s_awready <= 1'b0;
                  o_s_wready  <= 1'b1;
                  o_s_bid     <= i_s_awid;
                  w_idx       <= i_s_awaddr[BSH +: IDXW];
                  w_len       <= i_s_awlen;
                  w_beat      <= 8'd0;
                  w_err       <= i_s_awaddr >= SPAN;
                  w_bad       <= 1'b0;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_idx  <= w_idx + IDXW'(1);
                  w_beat <= w_beat + 8'd1;
                  w_bad  <= w_bad | w_mis;
                  if (w_final) begin
                     w_state    <= W_RESP;
                     o_s_wready <= 1'b0;
                     o_s_bvalid <= 1'b1;
                     o_s_bresp  <= w_err ? RESP_DECERR :
                                   (w_bad | w_mis) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            W_RESP: begin
               if (i_s_bready) begin
                  w_state     <= W_IDLE;
                  o_s_bvalid  <= 1'b0;
                  o_s_awready <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Byte-masked storage; contents survive reset, reads see pre-write data
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_hs && !w_err) begin
         for (int b = 0; b < int'(STBW); b++) begin
            if (i_s_wstrb[b]) mem[w_idx][b*8 +: 8] <= i_s_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: doc/axi4_s_ram.md
AXI4_S_RAM -- requirements
Module: axi4_s_ram

Interface
REQ-001 TAGW, 3, AXI ID width.
REQ-002 ADRW, 32, byte-address width.
REQ-003 DATW, 256, data width; STBW=DATW/8 derived; BSH=log2(STBW) derived.
REQ-004 DEPTH, 1024, memory words of DATW bits; power of two; span DEPTH*STBW bytes.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 i_clk  in  1  sole clock; all logic on rising edge.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 i_s_arid  in  TAGW  read ID.
REQ-009 i_s_araddr  in  ADRW  read start byte address.
REQ-010 i_s_arlen  in  8  beats minus one.
REQ-011 i_s_arvalid  in  1 / o_s_arready  out  1  read-address handshake.
REQ-012 o_s_rid  out  TAGW  echoed arid.
REQ-013 o_s_rdata  out  DATW  read beat.
REQ-014 o_s_rresp  out  2  00 OKAY, 11 DECERR.
REQ-015 o_s_rlast  out  1  final beat / o_s_rvalid  out  1 / i_s_rready  in  1.
REQ-016 i_s_awid  in  TAGW / i_s_awaddr  in  ADRW / i_s_awlen  in  8  write address phase.
REQ-017 i_s_awvalid  in  1 / o_s_awready  out  1  write-address handshake.
REQ-018 i_s_wdata  in  DATW / i_s_wstrb  in  STBW  byte enables.
REQ-019 i_s_wlast  in  1 / i_s_wvalid  in  1 / o_s_wready  out  1.
REQ-020 o_s_bid  out  TAGW / o_s_bresp  out  2 / o_s_bvalid  out  1 / i_s_bready  in  1.

Function
REQ-021 Size/burst/lock/cache/prot/region not ported; every burst is INCR, full DATW per beat.
REQ-022 Word index = addr[ADRW-1:BSH] + beat; low BSH bits ignored; index wraps modulo DEPTH.
REQ-023 Burst DECERR when addr >= DEPTH*STBW at AR/AW acceptance; whole burst DECERR, rdata all zero, writes suppressed.
REQ-024 Read FSM R_IDLE->R_DATA on arvalid&arready; arready=1 only in R_IDLE; one read outstanding.
REQ-025 First rvalid exactly 1 cycle after AR handshake; next beat 1 cycle after each rvalid&rready (0 bubbles).
REQ-026 rid/rdata/rresp/rlast stable while rvalid&!rready; rlast on beat arlen; R_DATA->R_IDLE on last handshake.
REQ-027 Write FSM W_IDLE->W_DATA on AW handshake ->W_RESP after beat awlen accepted ->W_IDLE on bvalid&bready.
REQ-028 awready=1 only in W_IDLE; wready=1 only in W_DATA; W beats before AW not accepted.
REQ-029 Each accepted beat writes only bytes with wstrb bit set, same cycle; strb 0 writes nothing.
REQ-030 Burst ends on count awlen+1 regardless of wlast; wlast mismatch -> bresp 10 SLVERR (DECERR overrides).
REQ-031 bvalid 1 cycle after final W handshake; bid = awid; held until bready.
REQ-032 Read and write channels independent; same-word same-cycle collision returns pre-write data (read-first).

Reset
REQ-033 i_rst: FSMs to idle, arready/awready=1, wready/rvalid/rlast/bvalid=0, rid/bid/rresp/bresp/rdata=0, burst aborted next cycle; memory contents preserved.

Verification
REQ-034 AW 0x40 len 3 + 4 beats strb all-ones, then AR 0x40 len 3 -> bresp 00 bid echoed; 4 beats match, rlast on beat 3, rvalid 1 cycle after AR.
REQ-035 Write 0x0 strb 0x0000000F data 0xAABBCCDD over preset word -> only bytes 0-3 change.
REQ-036 AR 0x8000 (DEPTH=1024) len 1 -> 2 beats rresp 11 data 0; AW same -> memory unchanged, bresp 11.
REQ-037 rready toggled 1/0 during len 7 read -> rdata stable when stalled, 8 beats in order, no drop/duplicate.
REQ-038 wlast on beat 1 of len 3 -> 4 beats accepted, bresp 10; i_rst mid-read -> rvalid 0 next cycle, arready 1.
